// File: rtl/chip_pkg.sv
// Shared definitions for the chip RV32I-subset core: widths, reset values,
// opcode/funct encodings, decode control payload and ALU operation enum.
// Optional feature macro used by the core: CHIP_MUL_EN (enables `mul`).
package chip_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned RIDX_W = 5;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0040_0000;
    localparam logic [XLEN-1:0] RESET_SP = 32'h7fff_effc;
    localparam logic [XLEN-1:0] RESET_GP = 32'h1000_8000;

    localparam logic [RIDX_W-1:0] REG_SP = 5'd2;
    localparam logic [RIDX_W-1:0] REG_GP = 5'd3;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OPIMM  = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;

    localparam logic [2:0] F3_ADD  = 3'b000;  // addi / add / sub / mul / jalr
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_WORD = 3'b010;  // lw / sw

    localparam logic [6:0] F7_BASE = 7'b000_0000;
    localparam logic [6:0] F7_ALT  = 7'b010_0000;
    localparam logic [6:0] F7_MUL  = 7'b000_0001;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_SLT = 3'd2,
        ALU_SLL = 3'd3,
        ALU_SRL = 3'd4,
        ALU_MUL = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_PC4 = 2'd1,
        WB_MEM = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_JAL    = 2'd1,
        PC_JALR   = 2'd2,
        PC_BRANCH = 2'd3
    } pc_sel_e;

    // Decoded control for the instruction currently at PC
    typedef struct packed {
        alu_op_e alu_op;
        logic    a_pc;    // ALU operand A is PC instead of rs1
        logic    b_imm;   // ALU operand B is immediate instead of rs2
        wb_sel_e wb_sel;
        pc_sel_e pc_sel;
        logic    rd_we;
        logic    mem_rd;
        logic    mem_wr;
    } ctrl_t;

    // Architectural reset value of each register
    function automatic logic [XLEN-1:0] reg_reset_val(input logic [RIDX_W-1:0] idx);
        case (idx)
            REG_SP:  return RESET_SP;
            REG_GP:  return RESET_GP;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/chip_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// x0 always reads zero and ignores writes; async reset loads sp/gp init values.
// Ports: clk, rst_n, ra1_i/ra2_i read addresses, rd1_o/rd2_o read data,
//        we_i/wa_i/wd_i write enable/address/data.
module chip_regfile
    import chip_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RIDX_W-1:0] ra1_i,
    input  logic [RIDX_W-1:0] ra2_i,
    output logic [XLEN-1:0]   rd1_o,
    output logic [XLEN-1:0]   rd2_o,
    input  logic              we_i,
    input  logic [RIDX_W-1:0] wa_i,
    input  logic [XLEN-1:0]   wd_i
);

    logic [XLEN-1:0] regs_q [NREG];

    // Register array; entry 0 is held at zero and never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= reg_reset_val(RIDX_W'(i));
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/chip.sv
// Single-cycle RV32I-subset core: auipc, jal, jalr, beq, bne, lw, sw, addi,
// slti, slli, srli, add, sub (+ mul when CHIP_MUL_EN is defined). Any other
// encoding is a NOP. Fetch/decode/execute are combinational; PC and register
// file update on the rising clock edge.
// Ports: clk, rst_n (async, active-low); mem_addr_I/mem_rdata_I instruction
//        port (address = PC); mem_wen_D/mem_addr_D/mem_wdata_D/mem_rdata_D
//        word-aligned data port with combinational read.
// Configuration macro: CHIP_MUL_EN.
module chip
    import chip_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_wen_D,
    output logic [XLEN-1:0] mem_addr_D,
    output logic [XLEN-1:0] mem_wdata_D,
    input  logic [XLEN-1:0] mem_rdata_D,
    output logic [XLEN-1:0] mem_addr_I,
    input  logic [XLEN-1:0] mem_rdata_I
);

    logic [XLEN-1:0]   pc_q, pc_d, pc_plus4;
    logic [6:0]        opcode, funct7;
    logic [2:0]        funct3;
    logic [RIDX_W-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_j, imm_u, op_imm;
    logic [XLEN-1:0]   rs1_val, rs2_val, alu_a, alu_b, alu_res, rd_wdata;
    ctrl_t             ctrl;

    assign opcode = mem_rdata_I[6:0];
    assign rd     = mem_rdata_I[11:7];
    assign funct3 = mem_rdata_I[14:12];
    assign rs1    = mem_rdata_I[19:15];
    assign rs2    = mem_rdata_I[24:20];
    assign funct7 = mem_rdata_I[31:25];

    // Immediate generator
    assign imm_i = {{20{mem_rdata_I[31]}}, mem_rdata_I[31:20]};
    assign imm_s = {{20{mem_rdata_I[31]}}, mem_rdata_I[31:25], mem_rdata_I[11:7]};
    assign imm_b = {{19{mem_rdata_I[31]}}, mem_rdata_I[31], mem_rdata_I[7],
                    mem_rdata_I[30:25], mem_rdata_I[11:8], 1'b0};
    assign imm_j = {{11{mem_rdata_I[31]}}, mem_rdata_I[31], mem_rdata_I[19:12],
                    mem_rdata_I[20], mem_rdata_I[30:21], 1'b0};
    assign imm_u = {mem_rdata_I[31:12], 12'h000};

    chip_regfile u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1_i (rs1),
        .ra2_i (rs2),
        .rd1_o (rs1_val),
        .rd2_o (rs2_val),
        .we_i  (ctrl.rd_we),
        .wa_i  (rd),
        .wd_i  (rd_wdata)
    );

    // Decode: unsupported encodings fall through with every enable low (NOP)
    always_comb begin
        ctrl.alu_op = ALU_ADD;
        ctrl.a_pc   = 1'b0;
        ctrl.b_imm  = 1'b1;
        ctrl.wb_sel = WB_ALU;
        ctrl.pc_sel = PC_PLUS4;
        ctrl.rd_we  = 1'b0;
        ctrl.mem_rd = 1'b0;
        ctrl.mem_wr = 1'b0;
        op_imm      = imm_i;
        case (opcode)
            OPC_AUIPC: begin
                ctrl.a_pc  = 1'b1;
                ctrl.rd_we = 1'b1;
                op_imm     = imm_u;
            end
            OPC_JAL: begin
                ctrl.rd_we  = 1'b1;
                ctrl.wb_sel = WB_PC4;
                ctrl.pc_sel = PC_JAL;
            end
            OPC_JALR: begin
                if (funct3 == F3_ADD) begin
                    ctrl.rd_we  = 1'b1;
                    ctrl.wb_sel = WB_PC4;
                    ctrl.pc_sel = PC_JALR;
                end
            end
            OPC_BRANCH: begin
                if (((funct3 == F3_BEQ) && (rs1_val == rs2_val)) ||
                    ((funct3 == F3_BNE) && (rs1_val != rs2_val))) begin
                    ctrl.pc_sel = PC_BRANCH;
                end
            end
            OPC_LOAD: begin
                if (funct3 == F3_WORD) begin
                    ctrl.rd_we  = 1'b1;
                    ctrl.wb_sel = WB_MEM;
                    ctrl.mem_rd = 1'b1;
                end
            end
            OPC_STORE: begin
                if (funct3 == F3_WORD) begin
                    ctrl.mem_wr = 1'b1;
                    op_imm      = imm_s;
                end
            end
            OPC_OPIMM: begin
                if (funct3 == F3_ADD) begin
                    ctrl.rd_we = 1'b1;
                end else if (funct3 == F3_SLT) begin
                    ctrl.rd_we  = 1'b1;
                    ctrl.alu_op = ALU_SLT;
                end else if ((funct3 == F3_SLL) && (funct7 == F7_BASE)) begin
                    ctrl.rd_we  = 1'b1;
                    ctrl.alu_op = ALU_SLL;
                end else if ((funct3 == F3_SRL) && (funct7 == F7_BASE)) begin
                    ctrl.rd_we  = 1'b1;
                    ctrl.alu_op = ALU_SRL;
                end
            end
            OPC_OP: begin
                ctrl.b_imm = 1'b0;
                if (funct3 == F3_ADD) begin
                    if (funct7 == F7_BASE) begin
                        ctrl.rd_we = 1'b1;
                    end else if (funct7 == F7_ALT) begin
                        ctrl.rd_we  = 1'b1;
                        ctrl.alu_op = ALU_SUB;
                    end
`ifdef CHIP_MUL_EN
                    else if (funct7 == F7_MUL) begin
                        ctrl.rd_we  = 1'b1;
                        ctrl.alu_op = ALU_MUL;
                    end
`endif
                end
            end
            default: ;
        endcase
    end

    assign alu_a = ctrl.a_pc ? pc_q : rs1_val;
    assign alu_b = ctrl.b_imm ? op_imm : rs2_val;

    // ALU; immediate shifts take shamt from the low 5 bits of operand B
    always_comb begin
        alu_res = '0;
        case (ctrl.alu_op)
            ALU_ADD: alu_res = alu_a + alu_b;
            ALU_SUB: alu_res = alu_a - alu_b;
            ALU_SLT: alu_res = XLEN'($signed(alu_a) < $signed(alu_b));
            ALU_SLL: alu_res = alu_a << alu_b[4:0];
            ALU_SRL: alu_res = alu_a >> alu_b[4:0];
`ifdef CHIP_MUL_EN
            ALU_MUL: alu_res = alu_a * alu_b;
`endif
            default: alu_res = '0;
        endcase
    end

    assign pc_plus4 = pc_q + 32'd4;

    // Next-PC selection
    always_comb begin
        pc_d = pc_plus4;
        case (ctrl.pc_sel)
            PC_JAL:    pc_d = pc_q + imm_j;
            PC_JALR:   pc_d = {alu_res[XLEN-1:1], 1'b0};
            PC_BRANCH: pc_d = pc_q + imm_b;
            default:   pc_d = pc_plus4;
        endcase
    end

    // Writeback mux; lw data comes straight from the combinational data port
    always_comb begin
        rd_wdata = alu_res;
        case (ctrl.wb_sel)
            WB_PC4:  rd_wdata = pc_plus4;
            WB_MEM:  rd_wdata = mem_rdata_D;
            default: rd_wdata = alu_res;
        endcase
    end

    // Program counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Data port; write enable is killed while reset is held
    assign mem_addr_I  = pc_q;
    assign mem_wen_D   = ctrl.mem_wr & rst_n;
    assign mem_addr_D  = (ctrl.mem_rd | ctrl.mem_wr) ? {alu_res[XLEN-1:2], 2'b00} : '0;
    assign mem_wdata_D = ctrl.mem_wr ? rs2_val : '0;

endmodule

// File: tb/tb_chip.sv
// Self-checking bench for chip: small programs are assembled into a text
// memory model; every expected store is queued before the program runs and
// compared when the core drives it onto the data port.
module tb_chip;

    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] GP0       = 32'h1000_8000;
    localparam logic [31:0] DWIN      = 32'h1001_0000;
    localparam logic [31:0] SWIN      = 32'h7fff_ef00;
    localparam int          IMEM_WORDS = 64;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    logic        clk;
    logic        rst_n;
    logic        mem_wen_D;
    logic [31:0] mem_addr_D, mem_wdata_D, mem_rdata_D, mem_addr_I, mem_rdata_I;

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [192];
    logic [31:0] prog [$];
    st_t         exp_q [$];
    int          checks = 0;
    int          errors = 0;

    chip dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_wen_D   (mem_wen_D),
        .mem_addr_D  (mem_addr_D),
        .mem_wdata_D (mem_wdata_D),
        .mem_rdata_D (mem_rdata_D),
        .mem_addr_I  (mem_addr_I),
        .mem_rdata_I (mem_rdata_I)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: three 64-word windows (gp area, 0x10010000, stack top)
    function automatic int dmap(input logic [31:0] a);
        if (a >= GP0 && a < GP0 + 32'd256) return int'((a - GP0) >> 2);
        if (a >= DWIN && a < DWIN + 32'd256) return 64 + int'((a - DWIN) >> 2);
        if (a >= SWIN && a < SWIN + 32'd256) return 128 + int'((a - SWIN) >> 2);
        return -1;
    endfunction

    function automatic logic [31:0] dread(input logic [31:0] a);
        int di;
        di = dmap(a);
        return (di >= 0) ? dmem[di] : 32'hdead_beef;
    endfunction

    always_comb begin
        logic [31:0] off;
        int di;
        off = mem_addr_I - TEXT_BASE;
        mem_rdata_I = (off < 32'(IMEM_WORDS * 4)) ? imem[off[7:2]] : NOP;
        di = dmap(mem_addr_D);
        mem_rdata_D = (di >= 0) ? dmem[di] : 32'h0;
    end

    always @(posedge clk) begin
        if (mem_wen_D === 1'b1 && dmap(mem_addr_D) >= 0) dmem[dmap(mem_addr_D)] <= mem_wdata_D;
    end

    // Scoreboard: each store the core issues pops and checks the next expected one
    always @(negedge clk) begin : store_mon
        st_t e;
        if (mem_wen_D === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL store_stray: got addr %h data %h, required no store", mem_addr_D, mem_wdata_D);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr_D !== e.addr || mem_wdata_D !== e.data) begin
                    errors++;
                    $display("FAIL store: got addr %h data %h, required addr %h data %h",
                             mem_addr_D, mem_wdata_D, e.addr, e.data);
                end
            end
        end
    end

    // Instruction encoders
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        logic [31:0] im;
        im = imm;
        return {im[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] im;
        im = imm;
        return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input int off, input int rs2, input int rs1, input int f3);
        logic [31:0] im;
        im = off;
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input int off, input int rd);
        logic [31:0] im;
        im = off;
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6f};
    endfunction
    function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
        logic [31:0] im;
        im = imm20;
        return {im[19:0], 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm); return enc_i(imm, rs1, 0, rd, 7'h13); endfunction
    function automatic logic [31:0] slti(input int rd, input int rs1, input int imm); return enc_i(imm, rs1, 2, rd, 7'h13); endfunction
    function automatic logic [31:0] slli(input int rd, input int rs1, input int sh);  return enc_i(sh, rs1, 1, rd, 7'h13); endfunction
    function automatic logic [31:0] srli(input int rd, input int rs1, input int sh);  return enc_i(sh, rs1, 5, rd, 7'h13); endfunction
    function automatic logic [31:0] lw(input int rd, input int imm, input int rs1);   return enc_i(imm, rs1, 2, rd, 7'h03); endfunction
    function automatic logic [31:0] sw(input int rs2, input int imm, input int rs1);  return enc_s(imm, rs2, rs1, 2); endfunction
    function automatic logic [31:0] jalr(input int rd, input int imm, input int rs1); return enc_i(imm, rs1, 0, rd, 7'h67); endfunction

    // Reset the core and load the program in prog into text memory
    task automatic load_program();
        rst_n = 1'b0;
        for (int i = 0; i < IMEM_WORDS; i++) imem[i] = (i < prog.size()) ? prog[i] : NOP;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_to(input logic [31:0] end_pc, input int budget, output bit reached);
        reached = 1'b0;
        for (int c = 0; c < budget && !reached; c++) begin
            @(negedge clk);
            if (mem_addr_I === end_pc) reached = 1'b1;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < IMEM_WORDS; i++) imem[i] = NOP;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_addr_I !== TEXT_BASE) begin errors++; $display("FAIL reset_pc: got %h required %h", mem_addr_I, TEXT_BASE); end
        checks++; if (mem_wen_D !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b required 0", mem_wen_D); end
        checks++; if (mem_addr_D !== 32'h0) begin errors++; $display("FAIL reset_daddr: got %h required 0", mem_addr_D); end
        checks++; if (mem_wdata_D !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h required 0", mem_wdata_D); end
        @(posedge clk);
        #1;
        checks++; if (mem_addr_I !== TEXT_BASE) begin errors++; $display("FAIL reset_hold_pc: got %h required %h", mem_addr_I, TEXT_BASE); end
    endtask

    task automatic test_store();
        bit ok;
        prog.delete();
        prog.push_back(addi(5, 0, 7));
        prog.push_back(enc_u(32'h0FC10, 3, 7'h17));   // auipc x3 -> 0x10010004
        prog.push_back(addi(3, 3, -4));
        prog.push_back(sw(5, 0, 3));
        load_program();
        exp_q.push_back('{addr: 32'h1001_0000, data: 32'h7});
        run_to(32'h0040_0010, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL store_end: fetch got %h required 00400010", mem_addr_I); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL store_missing: got %0d pending required 0", exp_q.size()); end
        checks++; if (dread(32'h1001_0000) !== 32'h7) begin errors++; $display("FAIL store_mem: got %h required 00000007", dread(32'h1001_0000)); end
    endtask

    task automatic test_alu();
        bit ok;
        logic [31:0] vals [10];
        int          regs [10];
        prog.delete();
        prog.push_back(addi(6, 0, -1));
        prog.push_back(slti(7, 6, 0));
        prog.push_back(enc_r(7'h20, 6, 0, 0, 8));       // sub x8,x0,x6
        prog.push_back(slli(10, 6, 4));
        prog.push_back(srli(11, 6, 28));
        prog.push_back(enc_r(0, 8, 7, 0, 12));          // add x12,x7,x8
        prog.push_back(slti(13, 7, 0));
        prog.push_back(enc_i(32'h401, 6, 5, 14, 7'h13)); // srai: NOP
        prog.push_back(enc_r(0, 0, 6, 6, 15));           // or: NOP
        prog.push_back(enc_u(32'h12345, 16, 7'h37));     // lui: NOP
        prog.push_back(enc_s(48, 6, 3, 1));              // sh: NOP
        regs = '{6, 7, 8, 10, 11, 12, 13, 14, 15, 16};
        vals = '{32'hFFFF_FFFF, 32'h1, 32'h1, 32'hFFFF_FFF0, 32'hF, 32'h2, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 10; i++) prog.push_back(sw(regs[i], 4 * i, 3));
        prog.push_back(sw(12, 41, 3));                   // misaligned store
        prog.push_back(lw(17, 43, 3));                   // misaligned load, then dependent store
        prog.push_back(sw(17, 44, 3));
        load_program();
        for (int i = 0; i < 10; i++) exp_q.push_back('{addr: GP0 + 32'(4 * i), data: vals[i]});
        exp_q.push_back('{addr: GP0 + 32'd40, data: 32'h2});
        exp_q.push_back('{addr: GP0 + 32'd44, data: 32'h2});
        run_to(32'h0040_0060, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL alu_end: fetch got %h required 00400060", mem_addr_I); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL alu_missing: got %0d pending required 0", exp_q.size()); end
        checks++; if (dread(GP0 + 32'd44) !== 32'h2) begin errors++; $display("FAIL alu_lw_use: got %h required 00000002", dread(GP0 + 32'd44)); end
    endtask

    task automatic test_branch();
        bit ok;
        prog.delete();
        prog.push_back(addi(5, 0, 1));
        prog.push_back(addi(6, 0, 1));
        prog.push_back(enc_b(8, 6, 5, 0));   // beq taken
        prog.push_back(addi(20, 0, 9));      // skipped
        prog.push_back(enc_b(8, 6, 5, 1));   // bne not taken
        prog.push_back(addi(21, 0, 5));
        prog.push_back(enc_b(8, 0, 5, 1));   // bne taken
        prog.push_back(addi(22, 0, 9));      // skipped
        prog.push_back(enc_b(8, 0, 5, 0));   // beq not taken
        prog.push_back(addi(23, 0, 6));
        prog.push_back(enc_j(8, 24));        // jal x24 -> skip next
        prog.push_back(addi(25, 0, 9));      // skipped
        for (int i = 0; i < 6; i++) prog.push_back(sw(20 + i, 4 * i, 3));
        load_program();
        exp_q.push_back('{addr: GP0,          data: 32'h0});
        exp_q.push_back('{addr: GP0 + 32'd4,  data: 32'h5});
        exp_q.push_back('{addr: GP0 + 32'd8,  data: 32'h0});
        exp_q.push_back('{addr: GP0 + 32'd12, data: 32'h6});
        exp_q.push_back('{addr: GP0 + 32'd16, data: 32'h0040_002C});
        exp_q.push_back('{addr: GP0 + 32'd20, data: 32'h0});
        run_to(32'h0040_0048, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL branch_end: fetch got %h required 00400048", mem_addr_I); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL branch_missing: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_call();
        bit ok;
        logic [31:0] s, ra;
        prog.delete();
        prog.push_back(addi(10, 0, 5));
        prog.push_back(enc_j(16, 1));        // jal ra, sum
        prog.push_back(sw(10, 0, 3));
        prog.push_back(sw(2, 4, 3));
        prog.push_back(enc_j(52, 0));        // jump to end
        prog.push_back(enc_b(8, 0, 10, 1));  // sum: bne a0,x0,recurse
        prog.push_back(jalr(0, 0, 1));
        prog.push_back(sw(1, -4, 2));
        prog.push_back(sw(10, -8, 2));
        prog.push_back(addi(2, 2, -8));
        prog.push_back(addi(10, 10, -1));
        prog.push_back(enc_j(-24, 1));
        prog.push_back(lw(5, 0, 2));
        prog.push_back(lw(1, 4, 2));
        prog.push_back(addi(2, 2, 8));
        prog.push_back(enc_r(0, 5, 10, 0, 10));
        prog.push_back(jalr(0, 0, 1));
        load_program();
        s  = 32'h7fff_effc;
        ra = 32'h0040_0008;
        for (int k = 5; k >= 1; k--) begin
            exp_q.push_back('{addr: s - 32'd4, data: ra});
            exp_q.push_back('{addr: s - 32'd8, data: 32'(k)});
            s  = s - 32'd8;
            ra = 32'h0040_0030;
        end
        exp_q.push_back('{addr: GP0,         data: 32'd15});
        exp_q.push_back('{addr: GP0 + 32'd4, data: 32'h7fff_effc});
        run_to(32'h0040_0044, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL call_end: fetch got %h required 00400044", mem_addr_I); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL call_missing: got %0d pending required 0", exp_q.size()); end
        checks++; if (dread(GP0) !== 32'd15) begin errors++; $display("FAIL call_result: got %h required 0000000f", dread(GP0)); end
    endtask

    task automatic test_mul();
        bit ok;
        prog.delete();
        prog.push_back(addi(5, 0, 1));
        prog.push_back(slli(5, 5, 16));
        prog.push_back(addi(5, 5, 1));
        prog.push_back(addi(6, 0, 77));
        prog.push_back(enc_r(1, 5, 5, 0, 6));   // mul x6,x5,x5
        prog.push_back(sw(6, 0, 3));
        load_program();
`ifdef CHIP_MUL_EN
        exp_q.push_back('{addr: GP0, data: 32'h0002_0001});
`else
        exp_q.push_back('{addr: GP0, data: 32'd77});
`endif
        run_to(32'h0040_0018, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mul_end: fetch got %h required 00400018", mem_addr_I); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mul_missing: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        prog.delete();
        prog.push_back(addi(5, 5, 1));
        prog.push_back(sw(5, 0, 3));
        prog.push_back(enc_j(-8, 0));
        load_program();
        exp_q.push_back('{addr: GP0, data: 32'h1});
        exp_q.push_back('{addr: GP0, data: 32'h2});
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;                 // next instruction would have been a store
        #1;
        checks++; if (mem_addr_I !== TEXT_BASE) begin errors++; $display("FAIL midrst_pc: got %h required %h", mem_addr_I, TEXT_BASE); end
        checks++; if (mem_wen_D !== 1'b0) begin errors++; $display("FAIL midrst_wen: got %b required 0", mem_wen_D); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_missing: got %0d pending required 0", exp_q.size()); end
        checks++; if (dread(GP0) !== 32'h2) begin errors++; $display("FAIL midrst_mem: got %h required 00000002", dread(GP0)); end
        rst_n = 1'b1;
        exp_q.push_back('{addr: GP0, data: 32'h1});  // x5 restarts from zero
        repeat (3) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_restart: got %0d pending required 0", exp_q.size()); end
    endtask

    initial begin
        rst_n = 1'b1;
        #1;
        test_reset();
        test_store();
        test_alu();
        test_branch();
        test_call();
        test_mul();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
